// File: rtl/mux4x1_sel_arbiter.sv
// Round-robin 4-channel grant scheduler that drives the select lines of a 4:1 mux.
// Each grant is held for at least DWELL cycles so the mux output stays stable,
// unless the granted channel drops its request first.
// Optional feature macro: MUX4X1_SEL_LOCK_EN. When it is defined, lock=1 pins the
// current grant for as long as its channel keeps requesting. When it is undefined,
// the lock input is ignored.
module mux4x1_sel_arbiter #(
    parameter int unsigned DWELL = 4,
    parameter int unsigned CW    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       lock,
    output logic       S1,
    output logic       S0,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       switch
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [CW-1:0] DwellLoad = CW'(DWELL - 1);

    state_e          state_q, state_d;
    logic [1:0]      cur_q, cur_d;
    logic [1:0]      last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      gnt_q, gnt_d;
    logic            valid_q, valid_d;
    logic            switch_q, switch_d;

    logic [1:0]      scan_base;
    logic [1:0]      winner;
    logic            lock_hold;
    logic            expire;

    // First requester after 'base'. Offset 4 wraps back to base itself, so base
    // only wins when it is the sole requester.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        rr_pick = base;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (r[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

`ifdef MUX4X1_SEL_LOCK_EN
    // Lock only pins a grant whose channel is still requesting.
    assign lock_hold = lock & req[cur_q];
`else
    logic unused_lock;
    assign unused_lock = lock;
    assign lock_hold   = 1'b0;
`endif

    // The scan starts after the last winner when idle and after the current owner
    // while granting. These are the same channel, but keeping them separate keeps
    // the reset priority (last=3) independent of the select reset (0).
    assign scan_base = (state_q == StIdle) ? last_q : cur_q;
    assign winner    = rr_pick(req, scan_base);
    assign expire    = ((cnt_q == '0) | ~req[cur_q]) & ~lock_hold;

    // Next-state and registered-output computation
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        valid_d  = valid_q;
        switch_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                gnt_d   = 4'b0000;
                if (|req) begin
                    state_d  = StGrant;
                    cur_d    = winner;
                    last_d   = winner;
                    gnt_d    = 4'b0001 << winner;
                    valid_d  = 1'b1;
                    cnt_d    = DwellLoad;
                    switch_d = 1'b1;
                end
            end
            StGrant: begin
                if (!expire) begin
                    // Not expired and not locked implies cnt is non-zero here.
                    if (!lock_hold) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else if (req == 4'b0000) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    gnt_d   = 4'b0000;
                end else begin
                    state_d  = StGrant;
                    cur_d    = winner;
                    last_d   = winner;
                    gnt_d    = 4'b0001 << winner;
                    valid_d  = 1'b1;
                    cnt_d    = DwellLoad;
                    switch_d = (winner != cur_q);
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cur_q    <= 2'd0;
            last_q   <= 2'd3;
            cnt_q    <= '0;
            gnt_q    <= 4'b0000;
            valid_q  <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
            switch_q <= switch_d;
        end
    end

    assign S1     = cur_q[1];
    assign S0     = cur_q[0];
    assign gnt    = gnt_q;
    assign valid  = valid_q;
    assign switch = switch_q;

endmodule

// File: tb/tb_mux4x1_sel_arbiter.sv
// Scoreboard bench for mux4x1_sel_arbiter: a cycle-level reference model pushes the
// expected outputs for every clock edge, and a monitor compares them on the falling edge.
module tb_mux4x1_sel_arbiter;

    localparam int DWELL = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       lock;
    logic       S1, S0;
    logic [3:0] gnt;
    logic       valid;
    logic       switch;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       vld;
        logic       sw;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: owner=-1 means nobody holds the mux
    int m_owner = -1;
    int m_last  = 3;
    int m_sel   = 0;
    int m_held  = 0;

    mux4x1_sel_arbiter #(
        .DWELL (DWELL),
        .CW    (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .lock   (lock),
        .S1     (S1),
        .S0     (S0),
        .gnt    (gnt),
        .valid  (valid),
        .switch (switch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return from;
    endfunction

    function automatic exp_t mk(input int sel, input logic [3:0] g, input logic v, input logic s);
        exp_t e;
        e.sel = 2'(sel);
        e.gnt = g;
        e.vld = v;
        e.sw  = s;
        return e;
    endfunction

    task automatic compare(input string name, input exp_t e);
        exp_t act;
        act = {S1, S0, gnt, valid, switch};
        n_checks++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got sel=%0d gnt=%b valid=%b switch=%b, expected sel=%0d gnt=%b valid=%b switch=%b",
                     name, $time, act.sel, act.gnt, act.vld, act.sw, e.sel, e.gnt, e.vld, e.sw);
        end
    endtask

    // Reference model: one step per rising edge, from the request/lock values at that edge
    initial begin : model
        logic [3:0] r;
        logic       lk;
        int         w;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_owner = -1;
                m_last  = 3;
                m_sel   = 0;
                m_held  = 0;
            end else begin
                r = req;
`ifdef MUX4X1_SEL_LOCK_EN
                lk = lock;
`else
                lk = 1'b0;
`endif
                if (m_owner < 0) begin
                    if (r != 4'b0000) begin
                        w = pick(r, m_last);
                        m_owner = w; m_last = w; m_sel = w; m_held = 1;
                        exp_q.push_back(mk(w, 4'(1 << w), 1'b1, 1'b1));
                    end else begin
                        exp_q.push_back(mk(m_sel, 4'b0000, 1'b0, 1'b0));
                    end
                end else if (r[m_owner] && (lk || m_held < DWELL)) begin
                    if (!lk) m_held++;
                    exp_q.push_back(mk(m_owner, 4'(1 << m_owner), 1'b1, 1'b0));
                end else if (r == 4'b0000) begin
                    m_owner = -1;
                    exp_q.push_back(mk(m_sel, 4'b0000, 1'b0, 1'b0));
                end else begin
                    w = pick(r, m_owner);
                    exp_q.push_back(mk(w, 4'(1 << w), 1'b1, logic'(w != m_owner)));
                    m_owner = w; m_last = w; m_sel = w; m_held = 1;
                end
            end
        end
    end

    // Monitor: compare on the falling edge, away from the active edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                compare("in_reset", mk(0, 4'b0000, 1'b0, 1'b0));
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare("scoreboard", e);
            end
        end
    end

    // Called at a falling edge: apply inputs, then spend n cycles
    task automatic drive(input logic [3:0] r, input logic l, input int n);
        #1;
        req  = r;
        lock = l;
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge: assert reset mid-cycle, check the immediate clear
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        compare("async_clear", mk(0, 4'b0000, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0;
        req   = 4'hF;
        lock  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        // Full request: rotation 0,1,2,3,0 including the 3->0 wrap
        drive(4'hF, 1'b0, 20);
        drive(4'h0, 1'b0, 2);

        // Single requester: held, re-granted every DWELL cycles without switch
        do_reset();
        drive(4'b0100, 1'b0, 10);
        drive(4'h0, 1'b0, 2);

        // Request drop mid-dwell with another requester waiting
        drive(4'b0010, 1'b0, 2);
        drive(4'b1000, 1'b0, 3);
        drive(4'h0, 1'b0, 2);
        // Request drop mid-dwell with nobody waiting: S1/S0 hold 01
        drive(4'b0010, 1'b0, 2);
        drive(4'h0, 1'b0, 3);

        // Reset in the middle of a grant on ch2, then priority restarts at ch0
        drive(4'b0100, 1'b0, 2);
        do_reset();
        drive(4'hF, 1'b0, 6);

        // Lock scenario
        do_reset();
        drive(4'b0001, 1'b0, 1);
        drive(4'hF, 1'b1, 10);
        drive(4'hF, 1'b0, 6);
        drive(4'b0110, 1'b1, 3);
        drive(4'b0100, 1'b1, 3);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            drive(4'($urandom_range(0, 15)), logic'($urandom_range(0, 3) == 0),
                  $urandom_range(1, 5));
        end
        drive(4'h0, 1'b0, 3);

        n_checks++;
        if (exp_q.size() > 1) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected at most 1", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
